// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Brief    : Size encodings, FSM state type and defaults for the data-memory
//             load/store path.
//  Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int MEM_WORDS_DEFAULT = 256;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_RMW_WRITE = 1'b1
    } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
//  Module   : load_align
//  Brief    : Selects the addressed byte/halfword lane of a memory word and
//             sign- or zero-extends it to 32 bits.
//  Revision : 1.0  initial release
// ============================================================================
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian lanes: byte k lives at bits [8k+7:8k]
    always_comb begin
        w_byte = 8'h00;
        case (offset)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        ext = rdata;
        case (size)
            SIZE_BYTE: ext = {{24{is_signed & w_byte[7]}}, w_byte};
            SIZE_HALF: ext = {{16{is_signed & w_half[15]}}, w_half};
            default:   ext = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Brief    : MEM-stage initiator for a word-wide data memory; sub-word stores
//             are a two-cycle read-modify-write, loads are extended and
//             registered.
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit
    import mem_pkg::*;
#(
    parameter int MEM_WORDS  = MEM_WORDS_DEFAULT,
    parameter int DATA_WIDTH = 32
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [1:0]            MemSize,
    input  logic                  MemSigned,
    input  logic [31:0]           Address,
    input  logic [DATA_WIDTH-1:0] Store_data,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] Load_data,
    output logic                  load_valid,
    output logic                  fault,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [32:0] c_ADDR_LIMIT = 33'(MEM_WORDS) << 2;

    lsu_state_t  r_state;
    logic [31:0] r_rmw_word;
    logic [1:0]  r_rmw_off;
    logic [1:0]  r_rmw_size;
    logic [15:0] r_rmw_data;
    logic [29:0] r_rmw_addr;
    logic [31:0] r_load_data;
    logic        r_load_valid;
    logic        r_fault;

    logic        w_idle;
    logic        w_align_ok;
    logic        w_in_range;
    logic        w_legal;
    logic        w_fault;
    logic        w_is_sub;
    logic        w_do_load;
    logic        w_do_wstore;
    logic        w_do_rmw;
    logic [31:0] w_load_ext;
    logic [31:0] w_merged;

    always_comb begin
        w_align_ok = 1'b0;
        case (MemSize)
            SIZE_BYTE: w_align_ok = 1'b1;
            SIZE_HALF: w_align_ok = ~Address[0];
            SIZE_WORD: w_align_ok = (Address[1:0] == 2'b00);
            default:   w_align_ok = 1'b0;
        endcase
    end

    assign w_idle      = (r_state == ST_IDLE);
    assign w_in_range  = ({1'b0, Address} < c_ADDR_LIMIT);
    assign w_legal     = req_valid & (MemRead ^ MemWrite) & w_align_ok & w_in_range;
    assign w_fault     = w_idle & req_valid & (MemRead | MemWrite) & ~w_legal;
    assign w_is_sub    = (MemSize != SIZE_WORD);
    assign w_do_load   = w_idle & w_legal & MemRead;
    assign w_do_wstore = w_idle & w_legal & MemWrite & ~w_is_sub;
    assign w_do_rmw    = w_idle & w_legal & MemWrite & w_is_sub;

    load_align u_load_align (
        .rdata     (mem_rdata),
        .offset    (Address[1:0]),
        .size      (MemSize),
        .is_signed (MemSigned),
        .ext       (w_load_ext)
    );

    // Merge uses only the offset/size/data captured in the read cycle
    always_comb begin
        w_merged = r_rmw_word;
        if (r_rmw_size == SIZE_BYTE) begin
            w_merged[{r_rmw_off, 3'b000} +: 8] = r_rmw_data[7:0];
        end else if (r_rmw_off[1]) begin
            w_merged[31:16] = r_rmw_data;
        end else begin
            w_merged[15:0] = r_rmw_data;
        end
    end

    // Strobes are gated by rst_n so nothing reaches memory while in reset
    assign mem_read  = rst_n & (w_do_load | w_do_rmw);
    assign mem_write = rst_n & (w_do_wstore | ~w_idle);
    assign stall     = rst_n & w_do_rmw;
    assign mem_addr  = w_idle ? {Address[31:2], 2'b00} : {r_rmw_addr, 2'b00};
    assign mem_wdata = w_idle ? Store_data : w_merged;

    assign Load_data  = r_load_data;
    assign load_valid = r_load_valid;
    assign fault      = r_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rmw_word   <= '0;
            r_rmw_off    <= '0;
            r_rmw_size   <= '0;
            r_rmw_data   <= '0;
            r_rmw_addr   <= '0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_load_valid <= w_do_load;
                    r_fault      <= w_fault;
                    if (w_do_load) begin
                        r_load_data <= w_load_ext;
                    end
                    if (w_do_rmw) begin
                        r_rmw_word <= mem_rdata;
                        r_rmw_off  <= Address[1:0];
                        r_rmw_size <= MemSize;
                        r_rmw_data <= Store_data[15:0];
                        r_rmw_addr <= Address[31:2];
                        r_state    <= ST_RMW_WRITE;
                    end
                end
                ST_RMW_WRITE: begin
                    r_load_valid <= 1'b0;
                    r_fault      <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Brief    : Directed vector bench for load_store_unit with a word memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  MemSize;
    logic        MemSigned;
    logic [31:0] Address;
    logic [31:0] Store_data;
    logic        stall;
    logic [31:0] Load_data;
    logic        load_valid;
    logic        fault;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];
    logic        tb_clear;

    int total;
    int bad;

    load_store_unit #(.MEM_WORDS(256), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemSize    (MemSize),
        .MemSigned  (MemSigned),
        .Address    (Address),
        .Store_data (Store_data),
        .stall      (stall),
        .Load_data  (Load_data),
        .load_valid (load_valid),
        .fault      (fault),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (tb_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (mem_write) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (mem_read && mem_write) begin
            bad = bad + 1;
            $display("FAIL strobe_exclusive: mem_read=%b mem_write=%b both high", mem_read, mem_write);
        end
    end

    typedef struct {
        logic        vld, rd, wr;
        logic [1:0]  sz;
        logic        sgn;
        logic [31:0] addr, sdata;
        logic        e_rd, e_wr, e_stall, e_fault, e_lv;
        logic [31:0] e_load;
        logic        e_chk_mem;
        logic [31:0] e_mem;
    } vec_t;

    function automatic vec_t mk(input logic vld, rd, wr, input logic [1:0] sz, input logic sgn,
                                input logic [31:0] addr, sdata,
                                input logic e_rd, e_wr, e_stall, e_fault, e_lv,
                                input logic [31:0] e_load, input logic e_chk_mem,
                                input logic [31:0] e_mem);
        vec_t v;
        v.vld = vld; v.rd = rd; v.wr = wr; v.sz = sz; v.sgn = sgn;
        v.addr = addr; v.sdata = sdata;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_stall = e_stall; v.e_fault = e_fault; v.e_lv = e_lv;
        v.e_load = e_load; v.e_chk_mem = e_chk_mem; v.e_mem = e_mem;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, rd, wr, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, sdata);
        req_valid = vld; MemRead = rd; MemWrite = wr; MemSize = sz;
        MemSigned = sgn; Address = addr; Store_data = sdata;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        drive(v.vld, v.rd, v.wr, v.sz, v.sgn, v.addr, v.sdata);
        #1;
        chk($sformatf("v%0d mem_read", idx), 32'(mem_read), 32'(v.e_rd));
        chk($sformatf("v%0d mem_write", idx), 32'(mem_write), 32'(v.e_wr));
        chk($sformatf("v%0d stall", idx), 32'(stall), 32'(v.e_stall));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d load_valid", idx), 32'(load_valid), 32'(v.e_lv));
        chk($sformatf("v%0d fault", idx), 32'(fault), 32'(v.e_fault));
        if (v.e_lv) chk($sformatf("v%0d Load_data", idx), Load_data, v.e_load);
        if (v.e_stall) begin
            // Scramble the request; the write must use the latched one
            drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF);
            #1;
            chk($sformatf("v%0d rmw mem_write", idx), 32'(mem_write), 32'd1);
            chk($sformatf("v%0d rmw mem_read", idx), 32'(mem_read), 32'd0);
            chk($sformatf("v%0d rmw stall", idx), 32'(stall), 32'd0);
            chk($sformatf("v%0d rmw mem_addr", idx), mem_addr, {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d rmw mem_wdata", idx), mem_wdata, v.e_mem);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d rmw load_valid", idx), 32'(load_valid), 32'd0);
            chk($sformatf("v%0d rmw fault", idx), 32'(fault), 32'd0);
        end
        if (v.e_chk_mem) chk($sformatf("v%0d memword", idx), mem[v.addr[9:2]], v.e_mem);
    endtask

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        tb_clear = 1'b1;
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

        //            vld rd wr sz     sgn addr   sdata           rd wr st flt lv load            chk mem
        vecs.push_back(mk(1,0,1,2'b10,0,32'h10, 32'hDEADBEEF, 0,1,0,0,0,32'h0,        1,32'hDEADBEEF));
        vecs.push_back(mk(1,1,0,2'b10,0,32'h10, 32'h0,        1,0,0,0,1,32'hDEADBEEF, 0,32'h0));
        vecs.push_back(mk(1,0,1,2'b10,0,32'h20, 32'h80FF7F01, 0,1,0,0,0,32'h0,        1,32'h80FF7F01));
        vecs.push_back(mk(1,1,0,2'b00,1,32'h23, 32'h0,        1,0,0,0,1,32'hFFFFFF80, 0,32'h0));
        vecs.push_back(mk(1,1,0,2'b00,0,32'h23, 32'h0,        1,0,0,0,1,32'h00000080, 0,32'h0));
        vecs.push_back(mk(1,1,0,2'b00,1,32'h20, 32'h0,        1,0,0,0,1,32'h00000001, 0,32'h0));
        vecs.push_back(mk(1,1,0,2'b00,1,32'h21, 32'h0,        1,0,0,0,1,32'h0000007F, 0,32'h0));
        vecs.push_back(mk(1,1,0,2'b00,1,32'h22, 32'h0,        1,0,0,0,1,32'hFFFFFFFF, 0,32'h0));
        vecs.push_back(mk(1,1,0,2'b01,1,32'h22, 32'h0,        1,0,0,0,1,32'hFFFF80FF, 0,32'h0));
        vecs.push_back(mk(1,1,0,2'b01,0,32'h22, 32'h0,        1,0,0,0,1,32'h000080FF, 0,32'h0));
        vecs.push_back(mk(1,1,0,2'b01,1,32'h20, 32'h0,        1,0,0,0,1,32'h00007F01, 0,32'h0));
        vecs.push_back(mk(1,0,1,2'b10,0,32'h30, 32'h11223344, 0,1,0,0,0,32'h0,        1,32'h11223344));
        vecs.push_back(mk(1,0,1,2'b00,0,32'h31, 32'h123456AA, 1,0,1,0,0,32'h0,        1,32'h1122AA44));
        vecs.push_back(mk(1,0,1,2'b01,0,32'h32, 32'hCAFEBEEF, 1,0,1,0,0,32'h0,        1,32'hBEEFAA44));
        vecs.push_back(mk(1,0,1,2'b00,0,32'h33, 32'h00000055, 1,0,1,0,0,32'h0,        1,32'h55EFAA44));
        vecs.push_back(mk(1,1,0,2'b10,0,32'h30, 32'h0,        1,0,0,0,1,32'h55EFAA44, 0,32'h0));
        vecs.push_back(mk(1,0,1,2'b01,0,32'h30, 32'h00001234, 1,0,1,0,0,32'h0,        1,32'h55EF1234));
        vecs.push_back(mk(1,0,1,2'b10,0,32'h3FC,32'h0BADF00D, 0,1,0,0,0,32'h0,        1,32'h0BADF00D));
        vecs.push_back(mk(1,1,0,2'b00,1,32'h3FF,32'h0,        1,0,0,0,1,32'h0000000B, 0,32'h0));
        // Faults and no-ops: no strobes, memory untouched
        vecs.push_back(mk(1,1,0,2'b10,0,32'h06, 32'h0,        0,0,0,1,0,32'h0,        1,32'h0));
        vecs.push_back(mk(1,1,0,2'b01,0,32'h05, 32'h0,        0,0,0,1,0,32'h0,        1,32'h0));
        vecs.push_back(mk(1,0,1,2'b10,0,32'h400,32'h12345678, 0,0,0,1,0,32'h0,        1,32'h0));
        vecs.push_back(mk(1,1,0,2'b00,0,32'h400,32'h0,        0,0,0,1,0,32'h0,        1,32'h0));
        vecs.push_back(mk(1,1,1,2'b10,0,32'h10, 32'h0,        0,0,0,1,0,32'h0,        1,32'hDEADBEEF));
        vecs.push_back(mk(1,0,1,2'b11,0,32'h10, 32'h0,        0,0,0,1,0,32'h0,        1,32'hDEADBEEF));
        vecs.push_back(mk(1,0,1,2'b01,0,32'h11, 32'h0,        0,0,0,1,0,32'h0,        1,32'hDEADBEEF));
        vecs.push_back(mk(0,1,0,2'b10,0,32'h10, 32'h0,        0,0,0,0,0,32'h0,        0,32'h0));
        vecs.push_back(mk(1,0,0,2'b10,0,32'h10, 32'h0,        0,0,0,0,0,32'h0,        0,32'h0));
        vecs.push_back(mk(1,0,1,2'b10,0,32'h40, 32'hA5A5A5A5, 0,1,0,0,0,32'h0,        1,32'hA5A5A5A5));

        // Reset state with a request pending
        repeat (2) @(posedge clk);
        #1;
        chk("reset mem_read", 32'(mem_read), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset Load_data", Load_data, 32'h0);
        chk("reset load_valid", 32'(load_valid), 32'd0);
        chk("reset fault", 32'(fault), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        tb_clear = 1'b0;
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Reset asserted during the RMW write cycle
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h41, 32'h000000CC);
        #1;
        chk("rst_rmw stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        chk("rst_rmw in_write", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_rmw mem_write", 32'(mem_write), 32'd0);
        chk("rst_rmw Load_data", Load_data, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_rmw memword", mem[16], 32'hA5A5A5A5);
        chk("rst_rmw idle mem_write", 32'(mem_write), 32'd0);
        chk("rst_rmw load_valid", 32'(load_valid), 32'd0);
        chk("rst_rmw fault", 32'(fault), 32'd0);
        run_vec(100, mk(1,1,0,2'b10,0,32'h40, 32'h0, 1,0,0,0,1,32'hA5A5A5A5, 0,32'h0));
        run_vec(101, mk(1,0,1,2'b00,0,32'h42, 32'h77, 1,0,1,0,0,32'h0, 1,32'hA577A5A5));

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("final load_valid", 32'(load_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
